// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Opcode encodings the fetch redirect logic cares about
//   - PC_mux select encodings driven by the control unit
//   - Bubble instruction encoding
//   - Fetch state enumeration
//   - Sign-extension helpers for branch/call offsets
package fetch_stage_pkg;

    localparam logic [3:0] OP_B    = 4'b1100;
    localparam logic [3:0] OP_CALL = 4'b1101;
    localparam logic [3:0] OP_RET  = 4'b1110;

    localparam logic [1:0] PC_SEQ  = 2'b01;
    localparam logic [1:0] PC_BR   = 2'b10;
    localparam logic [1:0] PC_CALL = 2'b00;

    localparam logic [15:0] NOP_INSTR = 16'hF000;

    typedef enum logic [1:0] {
        FS_RUN         = 2'd0,
        FS_MISS        = 2'd1,
        FS_MISS_SQUASH = 2'd2
    } fetch_state_e;

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    function automatic logic [15:0] sext12(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_calc.sv
// Combinational next-PC helper for the fetch stage.
// Ports:
//   ifid, ifid_pc, ifid_valid : instruction currently in IFID and its PC+1
//   stall_IFID, PC_mux, b_true : control-unit redirect qualifiers
//   ret_redirect, ret_target   : return redirect from MEM
//   pc                         : current fetch PC
//   brc                        : branch/call redirect taken this cycle
//   redirect                   : any redirect (return or branch/call)
//   redirect_target            : target of the highest-priority redirect
//   seq_pc                     : pc + 1
module next_pc_calc
    import fetch_stage_pkg::*;
(
    input  logic [15:0] ifid,
    input  logic [15:0] ifid_pc,
    input  logic        ifid_valid,
    input  logic        stall_IFID,
    input  logic [1:0]  PC_mux,
    input  logic        b_true,
    input  logic        ret_redirect,
    input  logic [15:0] ret_target,
    input  logic [15:0] pc,
    output logic        brc,
    output logic        redirect,
    output logic [15:0] redirect_target,
    output logic [15:0] seq_pc
);

    logic [15:0] br_target;
    logic [15:0] call_target;

    assign br_target   = ifid_pc + sext9(ifid[8:0]);
    assign call_target = ifid_pc + sext12(ifid[11:0]);
    assign seq_pc      = pc + 16'd1;

    assign brc = ifid_valid && !stall_IFID &&
                 (((PC_mux == PC_BR) && b_true) || (PC_mux == PC_CALL));

    assign redirect = ret_redirect || brc;

    // Return redirect outranks a branch/call on the IFID instruction.
    always_comb begin
        redirect_target = call_target;
        if (ret_redirect) begin
            redirect_target = ret_target;
        end else if (PC_mux == PC_BR) begin
            redirect_target = br_target;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache requests, loads IFID.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   stall_IFID         : decode stall, freezes PC and IFID
//   PC_mux, b_true     : next-PC select from control (01 seq, 10 branch, 00 call)
//   ret_redirect       : RET in MEM, ret_target valid
//   ret_target         : return address
//   icache_rdy         : icache hit / fill complete
//   icache_instr       : instruction word at icache_addr
//   icache_req         : fetch request (high whenever out of reset)
//   icache_addr        : fetch address
//   IFID, IFID_PC      : instruction register and its PC+1
//   IFID_valid         : IFID holds a real instruction
//   no_op_icache       : fetch is waiting on a miss
//   fetch_count        : instructions loaded into IFID (wraps)
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'hF000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_IFID,
    input  logic [1:0]  PC_mux,
    input  logic        b_true,
    input  logic        ret_redirect,
    input  logic [15:0] ret_target,
    input  logic        icache_rdy,
    input  logic [15:0] icache_instr,
    output logic        icache_req,
    output logic [15:0] icache_addr,
    output logic [15:0] IFID,
    output logic [15:0] IFID_PC,
    output logic        IFID_valid,
    output logic        no_op_icache,
    output logic [15:0] fetch_count
);
    import fetch_stage_pkg::*;

    fetch_state_e state, state_n;
    logic [15:0]  pc, pc_n;
    logic [15:0]  saved_target, saved_target_n;
    logic [15:0]  miss_addr, miss_addr_n;
    logic [15:0]  ifid_n, ifid_pc_n, fetch_count_n;
    logic         ifid_valid_n;

    logic         brc;
    logic         redirect;
    logic [15:0]  redirect_target;
    logic [15:0]  seq_pc;

    next_pc_calc u_next_pc (
        .ifid            (IFID),
        .ifid_pc         (IFID_PC),
        .ifid_valid      (IFID_valid),
        .stall_IFID      (stall_IFID),
        .PC_mux          (PC_mux),
        .b_true          (b_true),
        .ret_redirect    (ret_redirect),
        .ret_target      (ret_target),
        .pc              (pc),
        .brc             (brc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .seq_pc          (seq_pc)
    );

    assign icache_req   = !rst;
    // While squashing, the icache is still filling the abandoned address.
    assign icache_addr  = (state == FS_MISS_SQUASH) ? miss_addr : pc;
    assign no_op_icache = (state != FS_RUN);

    always_comb begin
        state_n        = state;
        pc_n           = pc;
        saved_target_n = saved_target;
        miss_addr_n    = miss_addr;
        ifid_n         = IFID;
        ifid_pc_n      = IFID_PC;
        ifid_valid_n   = IFID_valid;
        fetch_count_n  = fetch_count;

        unique case (state)
            // IFID is always a bubble in MISS, so brc cannot fire there and
            // RUN and MISS share one priority chain.
            FS_RUN, FS_MISS: begin
                if (redirect) begin
                    pc_n         = redirect_target;
                    ifid_n       = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                    if (!icache_rdy) begin
                        state_n        = FS_MISS_SQUASH;
                        saved_target_n = redirect_target;
                        miss_addr_n    = pc;
                    end else begin
                        state_n = FS_RUN;
                    end
                end else if (stall_IFID) begin
                    state_n = state;
                end else if (icache_rdy) begin
                    ifid_n        = icache_instr;
                    ifid_pc_n     = seq_pc;
                    ifid_valid_n  = 1'b1;
                    pc_n          = seq_pc;
                    fetch_count_n = fetch_count + 16'd1;
                    state_n       = FS_RUN;
                end else begin
                    ifid_n       = NOP_INSTR;
                    ifid_valid_n = 1'b0;
                    state_n      = FS_MISS;
                end
            end
            FS_MISS_SQUASH: begin
                if (ret_redirect) begin
                    saved_target_n = ret_target;
                end
                if (icache_rdy) begin
                    pc_n    = ret_redirect ? ret_target : saved_target;
                    state_n = FS_RUN;
                end
            end
            default: begin
                state_n = FS_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FS_RUN;
            pc           <= RESET_PC;
            saved_target <= '0;
            miss_addr    <= '0;
            IFID         <= NOP_INSTR;
            IFID_PC      <= '0;
            IFID_valid   <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            saved_target <= saved_target_n;
            miss_addr    <= miss_addr_n;
            IFID         <= ifid_n;
            IFID_PC      <= ifid_pc_n;
            IFID_valid   <= ifid_valid_n;
            fetch_count  <= fetch_count_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall_IFID, b_true, ret_redirect, icache_rdy;
    logic [1:0]  PC_mux;
    logic [15:0] ret_target, icache_instr;
    logic        icache_req, IFID_valid, no_op_icache;
    logic [15:0] icache_addr, IFID, IFID_PC, fetch_count;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'hF000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_IFID   (stall_IFID),
        .PC_mux       (PC_mux),
        .b_true       (b_true),
        .ret_redirect (ret_redirect),
        .ret_target   (ret_target),
        .icache_rdy   (icache_rdy),
        .icache_instr (icache_instr),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .IFID         (IFID),
        .IFID_PC      (IFID_PC),
        .IFID_valid   (IFID_valid),
        .no_op_icache (no_op_icache),
        .fetch_count  (fetch_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] m_pc, m_ifid, m_ifid_pc, m_count, m_target, m_hold;
    logic        m_valid;
    bit          m_waiting, m_squash;

    task automatic model_step();
        int          off;
        bit          take;
        logic [15:0] tgt;
        if (rst) begin
            m_pc = 16'h0000; m_ifid = 16'hF000; m_ifid_pc = 16'h0000;
            m_valid = 1'b0; m_count = 16'h0000; m_target = 16'h0000;
            m_hold = 16'h0000; m_waiting = 0; m_squash = 0;
        end else if (m_squash) begin
            if (ret_redirect) m_target = ret_target;
            if (icache_rdy) begin
                m_pc = m_target;
                m_squash = 0;
            end
        end else begin
            take = 0;
            tgt = 16'h0000;
            if (ret_redirect) begin
                take = 1;
                tgt = ret_target;
            end else if (m_valid && !stall_IFID && PC_mux == 2'b10 && b_true) begin
                take = 1;
                off = $signed(m_ifid[8:0]);
                tgt = m_ifid_pc + off[15:0];
            end else if (m_valid && !stall_IFID && PC_mux == 2'b00) begin
                take = 1;
                off = $signed(m_ifid[11:0]);
                tgt = m_ifid_pc + off[15:0];
            end
            if (take) begin
                m_ifid = 16'hF000;
                m_valid = 1'b0;
                m_waiting = 0;
                if (!icache_rdy) begin
                    m_squash = 1;
                    m_target = tgt;
                    m_hold = m_pc;
                end
                m_pc = tgt;
            end else if (stall_IFID) begin
                m_pc = m_pc;
            end else if (icache_rdy) begin
                m_ifid = icache_instr;
                m_pc = m_pc + 16'd1;
                m_ifid_pc = m_pc;
                m_valid = 1'b1;
                m_count = m_count + 16'd1;
                m_waiting = 0;
            end else begin
                m_ifid = 16'hF000;
                m_valid = 1'b0;
                m_waiting = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [15:0] instr, input logic stall,
                         input logic [1:0] mux, input logic bt, input logic ret,
                         input logic [15:0] rtgt);
        icache_rdy = rdy; icache_instr = instr; stall_IFID = stall;
        PC_mux = mux; b_true = bt; ret_redirect = ret; ret_target = rtgt;
    endtask

    // Plain sequential hits until the model's fetch PC reaches t.
    task automatic advance_to(input logic [15:0] t);
        int n = 0;
        drive(1'b1, 16'h0000, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        while (m_pc != t && n < 300) begin
            cycle();
            n++;
        end
        checks++;
        if (m_pc != t) begin
            errors++;
            $display("FAIL advance_to: reached %h required %h", m_pc, t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 16'h0000, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        cycle();
        checks++; if (icache_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", icache_req); end
        checks++; if (icache_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", icache_addr); end
        checks++; if (IFID !== 16'hF000) begin errors++; $display("FAIL reset_ifid: got %h want F000", IFID); end
        checks++; if (IFID_PC !== 16'h0000) begin errors++; $display("FAIL reset_ifid_pc: got %h want 0000", IFID_PC); end
        checks++; if (IFID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", IFID_valid); end
        checks++; if (no_op_icache !== 1'b0) begin errors++; $display("FAIL reset_noop: got %b want 0", no_op_icache); end
        checks++; if (fetch_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", fetch_count); end
        rst = 1'b0;
        #1;
        checks++; if (icache_req !== 1'b1) begin errors++; $display("FAIL run_req: got %b want 1", icache_req); end
    endtask

    task automatic test_hits();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
            checks++; if (icache_addr !== 16'(i)) begin errors++; $display("FAIL hit_addr: got %h want %h", icache_addr, 16'(i)); end
            cycle();
            checks++; if (IFID_PC !== 16'(i + 1)) begin errors++; $display("FAIL hit_ifid_pc: got %h want %h", IFID_PC, 16'(i + 1)); end
            checks++; if (IFID !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL hit_ifid: got %h want %h", IFID, 16'h0100 + 16'(i)); end
            checks++; if (no_op_icache !== 1'b0) begin errors++; $display("FAIL hit_noop: got %b want 0", no_op_icache); end
        end
        checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL hit_count: got %0d want 4", fetch_count); end
    endtask

    task automatic test_stall();
        drive(1'b1, 16'h1234, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'hDEAD, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000);
            cycle();
            checks++; if (IFID !== 16'h1234) begin errors++; $display("FAIL stall_ifid: got %h want 1234", IFID); end
            checks++; if (IFID_PC !== 16'h0005) begin errors++; $display("FAIL stall_ifid_pc: got %h want 0005", IFID_PC); end
            checks++; if (icache_addr !== 16'h0005) begin errors++; $display("FAIL stall_pc: got %h want 0005", icache_addr); end
            checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL stall_count: got %0d want 5", fetch_count); end
        end
        drive(1'b1, 16'h0200, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        checks++; if (icache_addr !== 16'h0006) begin errors++; $display("FAIL resume_pc: got %h want 0006", icache_addr); end
        checks++; if (IFID_PC !== 16'h0006) begin errors++; $display("FAIL resume_ifid_pc: got %h want 0006", IFID_PC); end
        checks++; if (IFID !== 16'h0200) begin errors++; $display("FAIL resume_ifid: got %h want 0200", IFID); end
    endtask

    task automatic test_branch();
        advance_to(16'h0010);
        drive(1'b1, 16'hC7FE, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        checks++; if (IFID_PC !== 16'h0011) begin errors++; $display("FAIL br_setup: got %h want 0011", IFID_PC); end
        drive(1'b1, 16'h0300, 1'b0, 2'b10, 1'b1, 1'b0, 16'h0000);
        cycle();
        checks++; if (icache_addr !== 16'h000F) begin errors++; $display("FAIL br_taken_pc: got %h want 000F", icache_addr); end
        checks++; if (IFID !== 16'hF000) begin errors++; $display("FAIL br_taken_ifid: got %h want F000", IFID); end
        checks++; if (IFID_valid !== 1'b0) begin errors++; $display("FAIL br_taken_valid: got %b want 0", IFID_valid); end
        advance_to(16'h0010);
        drive(1'b1, 16'hC7FE, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        drive(1'b1, 16'h0400, 1'b0, 2'b10, 1'b0, 1'b0, 16'h0000);
        cycle();
        checks++; if (icache_addr !== 16'h0012) begin errors++; $display("FAIL br_nt_pc: got %h want 0012", icache_addr); end
        checks++; if (IFID !== 16'h0400) begin errors++; $display("FAIL br_nt_ifid: got %h want 0400", IFID); end
        checks++; if (IFID_PC !== 16'h0012) begin errors++; $display("FAIL br_nt_ifid_pc: got %h want 0012", IFID_PC); end
        checks++; if (IFID_valid !== 1'b1) begin errors++; $display("FAIL br_nt_valid: got %b want 1", IFID_valid); end
    endtask

    task automatic test_call();
        advance_to(16'h001F);
        drive(1'b1, 16'hD010, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        drive(1'b1, 16'h0300, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000);
        cycle();
        checks++; if (icache_addr !== 16'h0030) begin errors++; $display("FAIL call_pc: got %h want 0030", icache_addr); end
        checks++; if (IFID !== 16'hF000) begin errors++; $display("FAIL call_bubble: got %h want F000", IFID); end
        drive(1'b1, 16'h0500, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        checks++; if (IFID !== 16'h0500) begin errors++; $display("FAIL call_next_ifid: got %h want 0500", IFID); end
        checks++; if (IFID_PC !== 16'h0031) begin errors++; $display("FAIL call_next_pc: got %h want 0031", IFID_PC); end
    endtask

    task automatic test_miss();
        advance_to(16'h0040);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h9999, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
            cycle();
            checks++; if (no_op_icache !== 1'b1) begin errors++; $display("FAIL miss_noop: got %b want 1", no_op_icache); end
            checks++; if (IFID !== 16'hF000) begin errors++; $display("FAIL miss_ifid: got %h want F000", IFID); end
            checks++; if (icache_addr !== 16'h0040) begin errors++; $display("FAIL miss_addr: got %h want 0040", icache_addr); end
        end
        drive(1'b1, 16'h0600, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        checks++; if (IFID !== 16'h0600) begin errors++; $display("FAIL fill_ifid: got %h want 0600", IFID); end
        checks++; if (icache_addr !== 16'h0041) begin errors++; $display("FAIL fill_pc: got %h want 0041", icache_addr); end
        checks++; if (no_op_icache !== 1'b0) begin errors++; $display("FAIL fill_noop: got %b want 0", no_op_icache); end
    endtask

    task automatic test_ret_squash();
        drive(1'b0, 16'h9999, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        drive(1'b0, 16'h9999, 1'b0, 2'b01, 1'b0, 1'b1, 16'h0080);
        cycle();
        checks++; if (no_op_icache !== 1'b1) begin errors++; $display("FAIL squash_noop: got %b want 1", no_op_icache); end
        checks++; if (icache_addr !== 16'h0041) begin errors++; $display("FAIL squash_addr: got %h want 0041", icache_addr); end
        drive(1'b1, 16'hBEEF, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        checks++; if (icache_addr !== 16'h0080) begin errors++; $display("FAIL ret_pc: got %h want 0080", icache_addr); end
        checks++; if (IFID !== 16'hF000) begin errors++; $display("FAIL ret_discard: got %h want F000", IFID); end
        checks++; if (IFID_valid !== 1'b0) begin errors++; $display("FAIL ret_valid: got %b want 0", IFID_valid); end
        drive(1'b1, 16'h0700, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
        cycle();
        checks++; if (IFID !== 16'h0700) begin errors++; $display("FAIL ret_next_ifid: got %h want 0700", IFID); end
        checks++; if (IFID_PC !== 16'h0081) begin errors++; $display("FAIL ret_next_pc: got %h want 0081", IFID_PC); end
    endtask

    task automatic test_random();
        logic [15:0] exp_addr;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 4) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), 16'($urandom));
            cycle();
            exp_addr = m_squash ? m_hold : m_pc;
            checks++; if (icache_req !== !rst) begin errors++; $display("FAIL rnd_req: got %b want %b", icache_req, !rst); end
            checks++; if (icache_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr: got %h want %h", icache_addr, exp_addr); end
            checks++; if (IFID !== m_ifid) begin errors++; $display("FAIL rnd_ifid: got %h want %h", IFID, m_ifid); end
            checks++; if (IFID_PC !== m_ifid_pc) begin errors++; $display("FAIL rnd_ifid_pc: got %h want %h", IFID_PC, m_ifid_pc); end
            checks++; if (IFID_valid !== m_valid) begin errors++; $display("FAIL rnd_valid: got %b want %b", IFID_valid, m_valid); end
            checks++; if (no_op_icache !== (m_waiting || m_squash)) begin errors++; $display("FAIL rnd_noop: got %b want %b", no_op_icache, (m_waiting || m_squash)); end
            checks++; if (fetch_count !== m_count) begin errors++; $display("FAIL rnd_count: got %h want %h", fetch_count, m_count); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hits();
        test_stall();
        test_branch();
        test_call();
        test_miss();
        test_ret_squash();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
